aes_stream_adapter: RTL and testbench

- Word-stream front/back end for the iterative AES-128 encryption core.
- Upstream: gathers a 128-bit key and a 128-bit plaintext from a narrow valid/ready word stream. Then holds them stable on the core inputs and pulses start.
- Downstream: captures the 128-bit ciphertext when the core signals done, and streams it out as words over valid/ready.
- Sits between the system bus/DMA and the AES core; the core sees only parallel 128-bit buses.

---
 rtl/aes_stream_adapter_pkg.sv | 22 ++
 rtl/aes_stream_adapter_if.sv | 23 ++
 rtl/aes_stream_adapter_serializer.sv | 57 +++++
 rtl/aes_stream_adapter.sv | 155 +++++++++++++++
 tb/tb_aes_stream_adapter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_adapter_pkg.sv
// Shared constants, state encoding and sizing helpers for the AES word-stream adapter.
package aes_stream_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int words_per_blk(input int word_w);
    return AES_BLK_W / word_w;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/aes_stream_adapter_if.sv
// Word-stream handshake bundle: input words toward the adapter, ciphertext words out of it.
interface aes_stream_adapter_if #(
  parameter int WORD_W = 32
);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/aes_stream_adapter_serializer.sv
// aes_word_serializer: captures a 128-bit block and streams it out most significant word first.
module aes_word_serializer
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] blk,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 drained
);

  localparam int NW = words_per_blk(WORD_W);
  localparam int OW = $clog2(NW);

  logic [NW-1:0][WORD_W-1:0] blk_w;
  logic [NW-1:0][WORD_W-1:0] cap;
  logic [OW-1:0]             out_cnt;
  logic [OW-1:0]             nxt_cnt;
  logic                      fire;

  assign blk_w   = blk;
  assign fire    = out_valid && out_ready && !flush;
  assign nxt_cnt = out_cnt + OW'(1);
  assign drained = fire && (out_cnt == OW'(NW - 1));

  // Word k sits at packed index NW-1-k, so the first word out is the top slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else if (load) begin
      cap       <= blk_w;
      out_data  <= blk_w[NW-1];
      out_valid <= 1'b1;
      out_cnt   <= '0;
    end else if (fire) begin
      out_cnt <= nxt_cnt;
      if (drained) begin
        out_valid <= 1'b0;
      end else begin
        out_data <= cap[OW'(NW - 1) - nxt_cnt];
      end
    end
  end

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-stream front/back end for the iterative AES-128 core.
// Optional watchdog on the core run is built when AES_STREAM_TIMEOUT_EN is defined.
//   state | meaning
//   LOAD  | gathering key then plaintext words
//   START | one-cycle core_start, core inputs held
//   WAIT  | core running, waiting for core_done
//   OUT   | streaming captured ciphertext words
module aes_stream_adapter
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = 32
`ifdef AES_STREAM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  aes_stream_adapter_if.slave        sif,
  output logic [AES_KEY_W-1:0]       core_key,
  output logic [AES_BLK_W-1:0]       core_plaintext,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic [AES_BLK_W-1:0]       core_ciphertext,
  output logic                       busy
`ifdef AES_STREAM_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  localparam int NW = words_per_blk(WORD_W);
  localparam int CW = cnt_w(2 * NW);
  localparam logic [CW-1:0] KEY_WORDS = CW'(NW);
  localparam logic [CW-1:0] LAST_WORD = CW'(2 * NW - 1);

  state_e        state, state_nx;
  logic [CW-1:0] in_cnt, in_cnt_nx;
  logic          in_fire;
  logic          cap_en;
  logic          drained;
  logic          tmo;

  assign sif.in_ready = (state == LOAD);
  assign in_fire      = (state == LOAD) && sif.in_valid && !flush;
  assign core_start   = (state == START);
  assign busy         = !((state == LOAD) && (in_cnt == '0));

`ifdef AES_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;
  logic          wait_tc;

  assign wait_tc = (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START) begin
        wait_cnt <= WAIT_LD;
      end else if ((state == WAIT) && !wait_tc) begin
        wait_cnt <= wait_cnt - TW'(1);
      end
      if (flush) begin
        timeout_err <= 1'b0;
      end else if (tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      in_cnt <= '0;
    end else begin
      state  <= state_nx;
      in_cnt <= in_cnt_nx;
    end
  end

  // core_done wins over an expiring watchdog in the same cycle.
  always_comb begin
    state_nx  = state;
    in_cnt_nx = in_cnt;
    cap_en    = 1'b0;
    tmo       = 1'b0;
    if (flush) begin
      state_nx  = LOAD;
      in_cnt_nx = '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (in_cnt == LAST_WORD) begin
              state_nx  = START;
              in_cnt_nx = '0;
            end else begin
              in_cnt_nx = in_cnt + CW'(1);
            end
          end
        end
        START: state_nx = WAIT;
        WAIT: begin
          if (core_done) begin
            cap_en   = 1'b1;
            state_nx = OUT;
          end
`ifdef AES_STREAM_TIMEOUT_EN
          else if (wait_tc) begin
            tmo      = 1'b1;
            state_nx = LOAD;
          end
`endif
        end
        OUT: begin
          if (drained) state_nx = LOAD;
        end
        default: state_nx = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key       <= '0;
      core_plaintext <= '0;
    end else if (in_fire) begin
      if (in_cnt < KEY_WORDS) begin
        core_key <= {core_key[AES_KEY_W-WORD_W-1:0], sif.in_data};
      end else begin
        core_plaintext <= {core_plaintext[AES_BLK_W-WORD_W-1:0], sif.in_data};
      end
    end
  end

  aes_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (cap_en),
    .blk       (core_ciphertext),
    .out_data  (sif.out_data),
    .out_valid (sif.out_valid),
    .out_ready (sif.out_ready),
    .drained   (drained)
  );

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Bench for aes_stream_adapter: a 32-bit instance and an 8-bit instance, each with a stand-in core.
module tb_aes_stream_adapter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int CORE_LAT = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        iv[2];
  logic [63:0] id[2];
  logic        ordy[2];
  logic        fdone[2];
  logic        done_en;

  logic        ir[2], ov[2], cs[2], by[2], cd[2];
  logic [63:0] od[2];
  logic [127:0] ck[2], cp[2], cct[2];
  int          dcnt[2];
  int          starts[2];

  logic [127:0] ck0, cp0, ck1, cp1;
  logic         cs0, cs1, by0, by1;
`ifdef AES_STREAM_TIMEOUT_EN
  logic         te0, te1;
`endif

  aes_stream_adapter_if #(.WORD_W(32)) if32 ();
  aes_stream_adapter_if #(.WORD_W(8))  if8 ();

  assign if32.in_valid  = iv[0];
  assign if32.in_data   = id[0][31:0];
  assign if32.out_ready = ordy[0];
  assign if8.in_valid   = iv[1];
  assign if8.in_data    = id[1][7:0];
  assign if8.out_ready  = ordy[1];

  aes_stream_adapter #(
    .WORD_W(32)
`ifdef AES_STREAM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .sif(if32),
    .core_key(ck0), .core_plaintext(cp0), .core_start(cs0),
    .core_done(cd[0]), .core_ciphertext(cct[0]), .busy(by0)
`ifdef AES_STREAM_TIMEOUT_EN
    , .timeout_err(te0)
`endif
  );

  aes_stream_adapter #(
    .WORD_W(8)
`ifdef AES_STREAM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .sif(if8),
    .core_key(ck1), .core_plaintext(cp1), .core_start(cs1),
    .core_done(cd[1]), .core_ciphertext(cct[1]), .busy(by1)
`ifdef AES_STREAM_TIMEOUT_EN
    , .timeout_err(te1)
`endif
  );

  always_comb begin
    ir[0] = if32.in_ready;   ir[1] = if8.in_ready;
    ov[0] = if32.out_valid;  ov[1] = if8.out_valid;
    od[0] = 64'(if32.out_data);
    od[1] = 64'(if8.out_data);
    ck[0] = ck0; ck[1] = ck1;
    cp[0] = cp0; cp[1] = cp1;
    cs[0] = cs0; cs[1] = cs1;
    by[0] = by0; by[1] = by1;
    for (int i = 0; i < 2; i++) cd[i] = (done_en && dcnt[i] == 1) || fdone[i];
  end

  // Stand-in for the AES core: the FIPS-197 vector gives the real answer, anything else a fixed mix.
  function automatic logic [127:0] ct_model(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i]) begin
        dcnt[i]   <= CORE_LAT;
        cct[i]    <= ct_model(ck[i], cp[i]);
        starts[i] <= starts[i] + 1;
      end else if (dcnt[i] > 0) begin
        dcnt[i] <= dcnt[i] - 1;
      end
    end
  end

  function automatic logic [63:0] word_of(input logic [127:0] f, input int j, input int w);
    logic [127:0] s;
    s = f >> (128 - (j + 1) * w);
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_word(input int i, input logic [63:0] w, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    iv[i] = 1'b1;
    id[i] = w;
    t = 0;
    while (!ir[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (ir[i] !== 1'b1) begin
      n_bad++;
      $display("FAIL in_ready_wait inst%0d: in_ready=%b required 1", i, ir[i]);
    end
    @(negedge clk);
    iv[i] = 1'b0;
  endtask

  task automatic send_block(input int i, input logic [127:0] k, input logic [127:0] p,
                            input int max_gap, input string nm);
    int w, nw;
    w  = (i == 0) ? 32 : 8;
    nw = 128 / w;
    for (int j = 0; j < 2 * nw; j++)
      send_word(i, (j < nw) ? word_of(k, j, w) : word_of(p, j - nw, w), $urandom_range(0, max_gap));
    n_cmp++;
    if (cs[i] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s core_start: got %b required 1", nm, cs[i]);
    end
    n_cmp++;
    if (ck[i] !== k) begin
      n_bad++;
      $display("FAIL %s core_key: got %h required %h", nm, ck[i], k);
    end
    n_cmp++;
    if (cp[i] !== p) begin
      n_bad++;
      $display("FAIL %s core_plaintext: got %h required %h", nm, cp[i], p);
    end
  endtask

  task automatic recv_block(input int i, input logic [127:0] exp, input int stall_word,
                            input int stall_len, input string nm);
    int w, nw, t;
    logic prev_cd;
    logic [63:0] ew;
    w  = (i == 0) ? 32 : 8;
    nw = 128 / w;
    ordy[i] = 1'b1;
    prev_cd = 1'b0;
    t = 0;
    while (!ov[i] && t < 200) begin
      prev_cd = cd[i];
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (ov[i] !== 1'b1 || prev_cd !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_valid: out_valid=%b done_prev_cycle=%b required 1/1", nm, ov[i], prev_cd);
    end
    for (int j = 0; j < nw; j++) begin
      ew = word_of(exp, j, w);
      n_cmp++;
      if (ov[i] !== 1'b1 || od[i] !== ew) begin
        n_bad++;
        $display("FAIL %s word%0d: valid=%b data=%h required 1/%h", nm, j, ov[i], od[i], ew);
      end
      n_cmp++;
      if (ir[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s in_ready_during_out%0d: got %b required 0", nm, j, ir[i]);
      end
      if (j == stall_word) begin
        ordy[i] = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          n_cmp++;
          if (ov[i] !== 1'b1 || od[i] !== ew) begin
            n_bad++;
            $display("FAIL %s stall_word%0d: valid=%b data=%h required 1/%h", nm, j, ov[i], od[i], ew);
          end
        end
        ordy[i] = 1'b1;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s drained: out_valid=%b in_ready=%b required 0/1", nm, ov[i], ir[i]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ir[i], ov[i], cs[i], by[i]} !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset_ctrl inst%0d: in_ready/out_valid/start/busy=%b%b%b%b required 1000",
                 i, ir[i], ov[i], cs[i], by[i]);
      end
      n_cmp++;
      if (od[i] !== 64'd0 || ck[i] !== 128'd0 || cp[i] !== 128'd0) begin
        n_bad++;
        $display("FAIL reset_data inst%0d: out_data=%h key=%h pt=%h required zeros", i, od[i], ck[i], cp[i]);
      end
    end
`ifdef AES_STREAM_TIMEOUT_EN
    n_cmp++;
    if (te0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_timeout_err: got %b required 0", te0);
    end
`endif
  endtask

  task automatic test_fips();
    int s;
    s = starts[0];
    send_block(0, FIPS_KEY, FIPS_PT, 0, "fips");
    recv_block(0, FIPS_CT, -1, 0, "fips");
    n_cmp++;
    if (starts[0] - s !== 1) begin
      n_bad++;
      $display("FAIL fips_start_count: got %0d required 1", starts[0] - s);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] k, p;
    for (int r = 0; r < 2; r++) begin
      k = rnd128();
      p = rnd128();
      send_block(0, k, p, 3, "bp");
      recv_block(0, ct_model(k, p), 1 + r, 10, "bp");
    end
  endtask

  task automatic test_flush();
    logic [127:0] k, p;
    int s;
    k = rnd128();
    p = rnd128();
    s = starts[0];
    for (int j = 0; j < 5; j++)
      send_word(0, (j < 4) ? word_of(k, j, 32) : word_of(p, j - 4, 32), $urandom_range(0, 2));
    iv[0] = 1'b1;
    id[0] = word_of(p, 1, 32);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    iv[0] = 1'b0;
    n_cmp++;
    if (by[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_state: busy=%b in_ready=%b required 0/1", by[0], ir[0]);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (starts[0] !== s) begin
      n_bad++;
      $display("FAIL flush_no_start: got %0d starts required 0", starts[0] - s);
    end
    send_block(0, FIPS_KEY, FIPS_PT, 1, "after_flush");
    recv_block(0, FIPS_CT, -1, 0, "after_flush");
  endtask

  task automatic test_reset_wait();
    int seen;
    send_block(0, rnd128(), rnd128(), 1, "rst_wait");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1 || by[0] !== 1'b0 || ov[0] !== 1'b0 || ck[0] !== 128'd0) begin
      n_bad++;
      $display("FAIL rst_wait_async: in_ready=%b busy=%b out_valid=%b key=%h required 1/0/0/0",
               ir[0], by[0], ov[0], ck[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fdone[0] = 1'b1;
    @(negedge clk);
    fdone[0] = 1'b0;
    seen = 0;
    repeat (CORE_LAT + 5) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    n_cmp++;
    if (seen !== 0 || ir[0] !== 1'b1 || by[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_done_ignored: valid_cycles=%0d in_ready=%b busy=%b required 0/1/0",
               seen, ir[0], by[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k, p;
    int s;
    s = starts[1];
    for (int b = 0; b < 2; b++) begin
      k = rnd128();
      p = rnd128();
      send_block(1, k, p, 1, "b2b_w8");
      recv_block(1, ct_model(k, p), -1, 0, "b2b_w8");
    end
    n_cmp++;
    if (starts[1] - s !== 2) begin
      n_bad++;
      $display("FAIL b2b_start_count: got %0d required 2", starts[1] - s);
    end
  endtask

`ifdef AES_STREAM_TIMEOUT_EN
  task automatic test_timeout();
    done_en = 1'b0;
    send_block(0, rnd128(), rnd128(), 0, "timeout");
    repeat (16) @(negedge clk);
    n_cmp++;
    if (te0 !== 1'b0 || ir[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_last_wait: err=%b in_ready=%b required 0/0", te0, ir[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (te0 !== 1'b1 || ir[0] !== 1'b1 || by[0] !== 1'b0 || ov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_fire: err=%b in_ready=%b busy=%b out_valid=%b required 1/1/0/0",
               te0, ir[0], by[0], ov[0]);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (te0 !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got %b required 1", te0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (te0 !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_flush_clear: got %b required 0", te0);
    end
    repeat (CORE_LAT + 5) @(negedge clk);
    done_en = 1'b1;
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL global_time_limit: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    done_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; id[i] = 64'd0; ordy[i] = 1'b0; fdone[i] = 1'b0;
      dcnt[i] = 0; starts[i] = 0; cct[i] = 128'd0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fips();
    test_backpressure();
    test_flush();
    test_reset_wait();
    test_back_to_back();
`ifdef AES_STREAM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
